// File: rtl/dc_err_pkg.sv
// Shared types and constants for the DC-error poll scheduler.
package dc_err_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_EVAL = 3'd3,
        ST_GAP  = 3'd4
    } state_e;

    localparam int DC_ERR_N_SRC  = 3;
    localparam int SRC_ET_DC     = 0;
    localparam int SRC_ET_OFC_DC = 1;
    localparam int SRC_VETO      = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dc_err_timer.sv
// Loadable down-counter that saturates at zero; shared by the reply timeout and the inter-round gap.
module dc_err_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/dc_err_poll_sched.sv
// Round-robin poller of the DC-error sources with per-source reply timeout.
// Build option DC_ERR_STICKY_EN: one bad round keeps is_dc_err high until in_live falls.
module dc_err_poll_sched
    import dc_err_pkg::*;
#(
    parameter int N_SRC       = DC_ERR_N_SRC,
    parameter int TIMEOUT_CYC = 1024,
    parameter int POLL_GAP    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_live,
    output logic [N_SRC-1:0] req_o,
    input  logic [N_SRC-1:0] got_i,
    input  logic [N_SRC-1:0] is_err_i,
    output logic             is_dc_err,
    output logic [N_SRC-1:0] err_src,
    output logic [N_SRC-1:0] tmo_src,
    output logic             round_done,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int TW = $clog2(max_int(TIMEOUT_CYC, POLL_GAP) + 1);
    localparam int GAP_M1 = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
    localparam logic [TW-1:0]    TMO_LOAD = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0]    GAP_LOAD = TW'(GAP_M1);
    localparam logic [N_SRC-1:0] ONE      = N_SRC'(1);
    localparam logic [IW-1:0]    LAST_IDX = IW'(N_SRC - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [N_SRC-1:0]  res_q, res_d;
    logic [N_SRC-1:0]  tmo_q, tmo_d;
    logic [N_SRC-1:0]  req_q, req_d;
    logic              is_dc_err_q, is_dc_err_d;
    logic [N_SRC-1:0]  err_src_q, err_src_d;
    logic [N_SRC-1:0]  tmo_src_q, tmo_src_d;
    logic              round_done_q, round_done_d;
    logic              busy_q, busy_d;
    logic              src_done;
    logic              tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0]     tmr_load_val;
`ifdef DC_ERR_STICKY_EN
    logic              sticky_q, sticky_d;
`endif

    dc_err_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Handshake: req_o[idx] is a one-cycle pulse in REQ; the source answers later with
    // got_i[idx] (is_err_i[idx] valid in the same cycle). Only the polled bit is looked at.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        res_d        = res_q;
        tmo_d        = tmo_q;
        req_d        = '0;
        is_dc_err_d  = is_dc_err_q;
        err_src_d    = err_src_q;
        tmo_src_d    = tmo_src_q;
        round_done_d = 1'b0;
        src_done     = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = TMO_LOAD;
        tmr_dec      = 1'b0;
`ifdef DC_ERR_STICKY_EN
        sticky_d     = sticky_q;
`endif
        if (!in_live) begin
            state_d     = ST_IDLE;
            idx_d       = '0;
            res_d       = '0;
            tmo_d       = '0;
            is_dc_err_d = 1'b1;
            err_src_d   = '0;
            tmo_src_d   = '0;
`ifdef DC_ERR_STICKY_EN
            sticky_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_REQ;
                    idx_d       = '0;
                    res_d       = '0;
                    tmo_d       = '0;
                    req_d       = ONE;
                    is_dc_err_d = 1'b1;
`ifdef DC_ERR_STICKY_EN
                    sticky_d    = 1'b0;
`endif
                end
                ST_REQ: begin
                    tmr_load     = 1'b1;
                    tmr_load_val = TMO_LOAD;
                    state_d      = ST_WAIT;
                end
                ST_WAIT: begin
                    if (got_i[idx_q]) begin
                        res_d[idx_q] = is_err_i[idx_q];
                        src_done     = 1'b1;
                    end else if (tmr_zero) begin
                        res_d[idx_q] = 1'b1;
                        tmo_d[idx_q] = 1'b1;
                        src_done     = 1'b1;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                    if (src_done) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_EVAL;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            req_d   = ONE << (idx_q + 1'b1);
                            state_d = ST_REQ;
                        end
                    end
                end
                ST_EVAL: begin
`ifdef DC_ERR_STICKY_EN
                    is_dc_err_d  = (|res_q) | sticky_q;
                    sticky_d     = sticky_q | (|res_q);
`else
                    is_dc_err_d  = |res_q;
`endif
                    err_src_d    = res_q;
                    tmo_src_d    = tmo_q;
                    round_done_d = 1'b1;
                    if (POLL_GAP == 0) begin
                        state_d = ST_REQ;
                        idx_d   = '0;
                        res_d   = '0;
                        tmo_d   = '0;
                        req_d   = ONE;
                    end else begin
                        tmr_load     = 1'b1;
                        tmr_load_val = GAP_LOAD;
                        state_d      = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tmr_zero) begin
                        state_d = ST_REQ;
                        idx_d   = '0;
                        res_d   = '0;
                        tmo_d   = '0;
                        req_d   = ONE;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            res_q        <= '0;
            tmo_q        <= '0;
            req_q        <= '0;
            is_dc_err_q  <= 1'b1;
            err_src_q    <= '0;
            tmo_src_q    <= '0;
            round_done_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef DC_ERR_STICKY_EN
            sticky_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            res_q        <= res_d;
            tmo_q        <= tmo_d;
            req_q        <= req_d;
            is_dc_err_q  <= is_dc_err_d;
            err_src_q    <= err_src_d;
            tmo_src_q    <= tmo_src_d;
            round_done_q <= round_done_d;
            busy_q       <= busy_d;
`ifdef DC_ERR_STICKY_EN
            sticky_q     <= sticky_d;
`endif
        end
    end

    assign req_o      = req_q;
    assign is_dc_err  = is_dc_err_q;
    assign err_src    = err_src_q;
    assign tmo_src    = tmo_src_q;
    assign round_done = round_done_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dc_err_poll_sched.sv
// Scoreboard bench for dc_err_poll_sched (TIMEOUT_CYC=8, POLL_GAP=2).
module tb_dc_err_poll_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_live = 1'b0;
    logic [2:0] req_o;
    logic [2:0] got_i = '0;
    logic [2:0] is_err_i = '0;
    logic       is_dc_err;
    logic [2:0] err_src;
    logic [2:0] tmo_src;
    logic       round_done;
    logic       busy;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic sticky_m = 1'b0;

    logic [2:0] exp_req_q[$];
    logic [6:0] exp_q[$];

    dc_err_poll_sched #(.N_SRC(3), .TIMEOUT_CYC(8), .POLL_GAP(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_live    (in_live),
        .req_o      (req_o),
        .got_i      (got_i),
        .is_err_i   (is_err_i),
        .is_dc_err  (is_dc_err),
        .err_src    (err_src),
        .tmo_src    (tmo_src),
        .round_done (round_done),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
    endtask

    // Monitor: pops expectations whenever the DUT presents a request or a round result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_o != 3'b000) begin
                if (exp_req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req actual=%b required=none t=%0t", req_o, $time);
                end else begin
                    check("req_o", {29'd0, req_o}, {29'd0, exp_req_q.pop_front()});
                end
            end
            if (round_done) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_round_done actual=1 required=0 t=%0t", $time);
                end else begin
                    check("round{dc,err,tmo}", {25'd0, is_dc_err, err_src, tmo_src},
                          {25'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (req_o == 3'b000 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (req_o == 3'b000) fail_now("wait_req");
    endtask

    task automatic wait_done();
        int n = 0;
        while (!round_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!round_done) fail_now("wait_round_done");
    endtask

    // Mode 0: reply next cycle; 1: never reply, stray got on another bit; 2: reply on expiry cycle.
    task automatic do_src(input int i, input int m, input logic e);
        wait_req();
        case (m)
            0: begin
                @(negedge clk); got_i[i] = 1'b1; is_err_i[i] = e;
                @(negedge clk); got_i = '0; is_err_i = '0;
            end
            1: begin
                @(negedge clk); got_i[(i + 2) % 3] = 1'b1;
                repeat (8) @(negedge clk);
                got_i = '0;
            end
            default: begin
                repeat (9) @(negedge clk);
                got_i[i] = 1'b1; is_err_i[i] = e;
                @(negedge clk); got_i = '0; is_err_i = '0;
            end
        endcase
    endtask

    task automatic do_round(input int m0, input int m1, input int m2, input logic [2:0] errs);
        logic [2:0] res, tmo;
        logic dc;
        int m[3];
        m[0] = m0; m[1] = m1; m[2] = m2;
        for (int i = 0; i < 3; i++) begin
            res[i] = (m[i] == 1) ? 1'b1 : errs[i];
            tmo[i] = (m[i] == 1);
        end
`ifdef DC_ERR_STICKY_EN
        dc = (|res) | sticky_m;
        sticky_m = sticky_m | (|res);
`else
        dc = |res;
`endif
        exp_req_q.push_back(3'b001);
        exp_req_q.push_back(3'b010);
        exp_req_q.push_back(3'b100);
        exp_q.push_back({dc, res, tmo});
        for (int i = 0; i < 3; i++) do_src(i, m[i], errs[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_o"}, {29'd0, req_o}, 32'd0);
        check({tag, "_is_dc_err"}, {31'd0, is_dc_err}, 32'd1);
        check({tag, "_err_src"}, {29'd0, err_src}, 32'd0);
        check({tag, "_tmo_src"}, {29'd0, tmo_src}, 32'd0);
        check({tag, "_round_done"}, {31'd0, round_done}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Clean round and first-round latency.
        c0 = cyc;
        in_live = 1'b1;
        do_round(0, 0, 0, 3'b000);
        wait_done();
        check("latency_cycles", cyc - c0, 32'd8);

        // Veto error, then a clean round.
        do_round(0, 0, 0, 3'b100);
        do_round(0, 0, 0, 3'b000);

        // ET OFC never replies.
        do_round(0, 1, 0, 3'b000);

        // Replies on the expiry cycle win over the timeout; stray got is ignored.
        do_round(2, 1, 2, 3'b100);
        do_round(2, 0, 0, 3'b001);
        wait_done();

        // Asynchronous reset in the middle of a WAIT.
        exp_req_q.push_back(3'b001);
        wait_req();
        repeat (2) @(negedge clk);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_wait_reset");
        in_live = 1'b0;
        sticky_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // in_live drops during WAIT of source 1, then restarts from source 0.
        in_live = 1'b1;
        do_round(0, 0, 0, 3'b100);
        exp_req_q.push_back(3'b001);
        exp_req_q.push_back(3'b010);
        do_src(0, 0, 1'b0);
        wait_req();
        @(negedge clk);
        in_live = 1'b0;
        sticky_m = 1'b0;
        @(negedge clk);
        check_idle_outputs("live_drop");
        repeat (5) @(negedge clk);
        in_live = 1'b1;
        do_round(0, 0, 0, 3'b000);
        wait_done();
        in_live = 1'b0;
        repeat (4) @(negedge clk);

        check("exp_req_q_left", exp_req_q.size(), 32'd0);
        check("exp_q_left", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

endmodule
